// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: per-bank issue selection between one reservation-station
// bank and its functional-unit group. Each cycle it binds up to NUM_FU ready
// entries, in round-robin order, to the free FUs. It tracks occupancy of
// non-pipelined FUs and clears all state on a branch-recovery flush.
// Optional feature: define ISSUE_PERF_CNT_EN to add the perf_issued and
// perf_stall_cycles counter outputs.
module rs_issue_scheduler #(
  parameter int RS_SZ      = 8,
  parameter int NUM_FU     = 2,
  parameter int FU_LATENCY = 1,
  parameter int IDX_W      = $clog2(RS_SZ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [RS_SZ-1:0]        entry_ready,
  input  logic                    flush,
  input  logic [NUM_FU-1:0]       fu_stall,
  output logic [NUM_FU-1:0]       issue_valid,
  output logic [NUM_FU*IDX_W-1:0] issue_idx,
  output logic [RS_SZ-1:0]        issue_clear,
`ifdef ISSUE_PERF_CNT_EN
  output logic [31:0]             perf_issued,
  output logic [31:0]             perf_stall_cycles,
`endif
  output logic [NUM_FU-1:0]       fu_busy
);

  logic [IDX_W-1:0]  rrPtr_q;
  logic [IDX_W-1:0]  rrPtr_d;
  logic [NUM_FU-1:0] fuIdle;
  logic [NUM_FU-1:0] fuAvail;
  logic [NUM_FU-1:0] fuFree;
  logic [IDX_W-1:0]  scanSel;
  logic [IDX_W-1:0]  lastSel;
  logic              anyGrant;
  logic              placed;
  int                scanPos;

  // Reset and flush both hold every FU unavailable, which is what silences the issue outputs.
  assign fuAvail = fuIdle & ~fu_stall & {NUM_FU{~flush & ~reset}};

  // Scan from rrPtr_q with wrap at RS_SZ, and bind each ready entry to the lowest-index free FU.
  always_comb begin
    issue_valid = '0;
    issue_idx   = '0;
    issue_clear = '0;
    fuFree      = fuAvail;
    lastSel     = rrPtr_q;
    anyGrant    = 1'b0;
    placed      = 1'b0;
    scanPos     = 0;
    scanSel     = '0;
    for (int j = 0; j < RS_SZ; j++) begin
      scanPos = int'(rrPtr_q) + j;
      if (scanPos >= RS_SZ) scanPos = scanPos - RS_SZ;
      scanSel = IDX_W'(scanPos);
      placed  = 1'b0;
      if (entry_ready[scanSel]) begin
        for (int k = 0; k < NUM_FU; k++) begin
          if (!placed && fuFree[k]) begin
            placed                       = 1'b1;
            fuFree[k]                    = 1'b0;
            issue_valid[k]               = 1'b1;
            issue_idx[k*IDX_W +: IDX_W]  = scanSel;
            issue_clear[scanSel]         = 1'b1;
            lastSel                      = scanSel;
            anyGrant                     = 1'b1;
          end
        end
      end
    end
  end

  // Priority moves just past the last granted entry; flush returns it to entry 0.
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (flush) begin
      rrPtr_d = '0;
    end else if (anyGrant) begin
      rrPtr_d = (lastSel == IDX_W'(RS_SZ - 1)) ? '0 : lastSel + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rrPtr_q <= '0;
    else       rrPtr_q <= rrPtr_d;
  end

  generate
    if (FU_LATENCY > 1) begin : gBusy
      localparam int CNT_W = $clog2(FU_LATENCY + 1);
      logic [CNT_W-1:0] busyCnt_q [NUM_FU];
      logic [CNT_W-1:0] busyCnt_d [NUM_FU];

      // A grant reloads the counter. Otherwise it counts down to zero, stall or not; flush zeroes it.
      always_comb begin
        for (int k = 0; k < NUM_FU; k++) begin
          busyCnt_d[k] = busyCnt_q[k];
          if (flush) begin
            busyCnt_d[k] = '0;
          end else if (issue_valid[k]) begin
            busyCnt_d[k] = CNT_W'(FU_LATENCY - 1);
          end else if (busyCnt_q[k] != '0) begin
            busyCnt_d[k] = busyCnt_q[k] - 1'b1;
          end
        end
      end

      // Occupancy counters; reset clears them asynchronously.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < NUM_FU; k++) busyCnt_q[k] <= '0;
        end else begin
          for (int k = 0; k < NUM_FU; k++) busyCnt_q[k] <= busyCnt_d[k];
        end
      end

      // An FU is idle once its counter has drained.
      always_comb begin
        for (int k = 0; k < NUM_FU; k++) fuIdle[k] = (busyCnt_q[k] == '0);
      end
    end else begin : gNoBusy
      assign fuIdle = '1;
    end
  endgenerate

  assign fu_busy = ~fuIdle;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perfIssued_q;
  logic [31:0] perfStall_q;

  // Issue and starvation counters. Flush does not clear them; they wrap at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perfIssued_q <= '0;
      perfStall_q  <= '0;
    end else begin
      perfIssued_q <= perfIssued_q + 32'($countones(issue_valid));
      if ((entry_ready != '0) && (issue_valid == '0)) perfStall_q <= perfStall_q + 32'd1;
    end
  end

  assign perf_issued       = perfIssued_q;
  assign perf_stall_cycles = perfStall_q;
`endif

endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
Per-bank issue scheduler for the reservation stations that the dispatch stage fills. Each cycle it selects up to NUM_FU ready RS entries using round-robin priority and binds each to a free functional unit. It tracks occupancy of non-pipelined FUs with countdown counters and honours FU back-pressure and branch-recovery flush. One instance sits between each RS bank and its FU group (ALU, MULT, BRANCH, MEM).

Parameters:
RS_SZ, 8, number of RS entries in the bank (any value >= 2, not necessarily a power of two)
NUM_FU, 2, functional units served by this bank (1..4)
FU_LATENCY, 1, cycles an FU is occupied per op; 1 = fully pipelined, never busy
IDX_W, $clog2(RS_SZ), width of an RS entry index (derived, do not override)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
entry_ready  input  RS_SZ  bit i = RS entry i valid with both operands ready
flush  input  1  squash: no issue this cycle, scheduler state cleared
fu_stall  input  NUM_FU  bit k = FU k cannot accept an op this cycle
issue_valid  output  NUM_FU  bit k = FU k receives an op this cycle
issue_idx  output  NUM_FU*IDX_W  RS index issued to FU k (slice k); 0 when issue_valid[k]=0
issue_clear  output  RS_SZ  one-hot-per-grant mask of entries issued; RS frees them at the next edge
fu_busy  output  NUM_FU  bit k = FU k occupancy counter nonzero

Behaviour:
- State: rr_ptr (IDX_W bits, range 0..RS_SZ-1); busy_cnt[k] ($clog2(FU_LATENCY+1) bits) per FU.
- Reset (async, active-high): rr_ptr=0, all busy_cnt=0. Outputs issue_valid, issue_idx, issue_clear are forced 0 while reset is high. fu_busy=0.
- fu_avail[k] = (busy_cnt[k]==0) && !fu_stall[k] && !flush.
- Selection is combinational, zero latency: outputs in the same cycle as entry_ready.
  - Scan entries in order rr_ptr, rr_ptr+1, ..., wrapping modulo RS_SZ (wrap at RS_SZ, not at 2^IDX_W).
  - Assign the 1st ready entry to the lowest-index available FU, the 2nd to the next available FU, and so on.
  - Stop when available FUs or ready entries are exhausted.
  - An entry is granted at most once per cycle.
- issue_clear = OR of the one-hot masks of all granted entries. Popcount(issue_clear) == popcount(issue_valid).
- Sequential update at rising clock edge (no flush):
  - If any grant occurred, rr_ptr <= (index of the last granted entry in scan order + 1) mod RS_SZ. Otherwise rr_ptr is unchanged.
  - For a granted FU k with FU_LATENCY>1: busy_cnt[k] <= FU_LATENCY-1.
  - For a non-granted FU k with busy_cnt[k]>0: busy_cnt[k] <= busy_cnt[k]-1.
  - Counters saturate at 0.
- FU_LATENCY==1: busy_cnt is constant 0 and fu_busy is tied low.
- fu_stall does not freeze busy_cnt; counters still decrement while stalled.
- flush: issue outputs are 0 in that cycle. At the edge, rr_ptr<=0 and all busy_cnt<=0. flush has priority over every other update.
- Reset mid-occupancy: counters clear immediately (asynchronously). The first issue is possible in the first cycle after reset deasserts.
- All ready with all FUs free: exactly min(NUM_FU, popcount(entry_ready)) grants.
- No ready entries: outputs 0, rr_ptr holds.

Optional Feature:
ISSUE_PERF_CNT_EN:
- Defined: adds outputs perf_issued (32b) and perf_stall_cycles (32b), both reset to 0 and cleared on reset only (not on flush).
  - perf_issued += popcount(issue_valid) each cycle.
  - perf_stall_cycles += 1 in any cycle where entry_ready!=0 and no grant occurs.
  - Both counters wrap modulo 2^32.
- Undefined: these ports and counters do not exist. Issue behaviour is identical.

Test Plan:
- Round-robin (RS_SZ=8, NUM_FU=2, FU_LATENCY=1): reset, entry_ready=8'hFF -> grants idx 0,1, rr_ptr=2. Next cycle -> grants 2,3. After 4 cycles rr_ptr back to 0 (wrap).
- Wrap with non-power-of-two (RS_SZ=6): rr_ptr=5, entry_ready=6'b000011 plus bit5 set -> FU0 gets 5, FU1 gets 0. Next rr_ptr=1.
- Non-pipelined FU (NUM_FU=1, FU_LATENCY=4): grant at cycle 0 -> fu_busy high cycles 1-3, no issue cycles 1-3 despite ready entries. Issue resumes at cycle 4.
- Back-pressure: fu_stall=2'b01, entry_ready=8'h0C, rr_ptr=0 -> only FU1 issues idx 2. issue_clear=8'h04. rr_ptr=3.
- Flush during occupancy (FU_LATENCY=4): grant at cycle 0, flush at cycle 1 -> no issue at cycle 1. Cycle 2: fu_busy=0, rr_ptr=0, issue of entry 0 if ready.
- Async reset mid-operation: assert reset between edges with busy_cnt=2 -> fu_busy and issue_valid drop to 0 immediately. After deassertion, first grant uses rr_ptr=0.
